// File: rtl/controle_irrigacao.sv
// Irrigation sequencer: synchronised trigger/sensors drive a timed valve
// cycle followed by a drain cooldown, with tank-low and level-fault reporting.
module controle_irrigacao #(
  parameter int IRRIG_TICKS = 8,
  parameter int DRAIN_TICKS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       gatilho_in,
  input  logic [1:0] umidade,
  input  logic       nivel_l,
  input  logic       nivel_m,
  input  logic       nivel_h,
  input  logic       modo,
  output logic       valvula_asp,
  output logic       valvula_got,
  output logic       alarme,
  output logic       erro_sensor,
  output logic [2:0] estado,
  output logic [7:0] ciclos
);

  localparam int DRIP_TICKS = 2 * IRRIG_TICKS;
  localparam int MAX_TICKS  = (DRIP_TICKS > DRAIN_TICKS) ?
                              DRIP_TICKS : DRAIN_TICKS;
  localparam int CW = $clog2(MAX_TICKS + 1);

  localparam logic [CW-1:0] IRRIG_CNT = CW'(IRRIG_TICKS);
  localparam logic [CW-1:0] DRIP_CNT  = CW'(DRIP_TICKS);
  localparam logic [CW-1:0] DRAIN_CNT = CW'(DRAIN_TICKS);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    REGA  = 3'd2,
    PAUSA = 3'd3,
    ERRO  = 3'd4
  } state_t;

  logic [6:0] raw;
  logic [6:0] sync1_q;
  logic [6:0] sync2_q;
  logic       gat_prev_q;

  assign raw = {gatilho_in, umidade, nivel_h, nivel_m, nivel_l, modo};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      gat_prev_q <= 1'b0;
    end else begin
      sync1_q    <= raw;
      sync2_q    <= sync1_q;
      gat_prev_q <= sync2_q[6];
    end
  end

  logic       gat_s;
  logic [1:0] umid_s;
  logic       nh_s;
  logic       nm_s;
  logic       nl_s;
  logic       modo_s;
  logic       trig_edge;
  logic       level_fault;

  assign gat_s       = sync2_q[6];
  assign umid_s      = sync2_q[5:4];
  assign nh_s        = sync2_q[3];
  assign nm_s        = sync2_q[2];
  assign nl_s        = sync2_q[1];
  assign modo_s      = sync2_q[0];
  assign trig_edge   = gat_s & ~gat_prev_q;
  assign level_fault = (nh_s & ~nm_s) | (nm_s & ~nl_s);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          modo_q, modo_d;
  logic          alarme_q, alarme_d;
  logic [7:0]    ciclos_q, ciclos_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      modo_q   <= 1'b0;
      alarme_q <= 1'b0;
      ciclos_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      modo_q   <= modo_d;
      alarme_q <= alarme_d;
      ciclos_q <= ciclos_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    modo_d   = modo_q;
    alarme_d = alarme_q;
    ciclos_d = ciclos_q;
    case (state_q)
      IDLE: begin
        if (trig_edge) state_d = CHECK;
      end
      CHECK: begin
        if (level_fault) begin
          state_d = ERRO;
        end else if (!nl_s) begin
          alarme_d = 1'b1;
          state_d  = IDLE;
        end else if (umid_s[1]) begin
          state_d = IDLE;
        end else begin
          alarme_d = 1'b0;
          modo_d   = modo_s;
          cnt_d    = modo_s ? DRIP_CNT : IRRIG_CNT;
          state_d  = REGA;
        end
      end
      REGA: begin
        if (level_fault) begin
          state_d = ERRO;
        end else if (!nl_s) begin
          alarme_d = 1'b1;
          cnt_d    = DRAIN_CNT;
          state_d  = PAUSA;
        end else if (umid_s == 2'b11) begin
          cnt_d   = DRAIN_CNT;
          state_d = PAUSA;
        end else if (cnt_q == CNT_ONE) begin
          if (ciclos_q != 8'hFF) ciclos_d = ciclos_q + 8'd1;
          cnt_d   = DRAIN_CNT;
          state_d = PAUSA;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      PAUSA: begin
        if (cnt_q == CNT_ONE) state_d = IDLE;
        else                  cnt_d   = cnt_q - CNT_ONE;
      end
      ERRO: begin
        state_d = ERRO;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Moore decode of registered state only, so reset clears valves at once
  assign valvula_asp = (state_q == REGA) & ~modo_q;
  assign valvula_got = (state_q == REGA) &  modo_q;
  assign erro_sensor = (state_q == ERRO);
  assign alarme      = alarme_q;
  assign estado      = state_q;
  assign ciclos      = ciclos_q;

endmodule

// File: tb/tb_controle_irrigacao.sv
// Randomised bench for controle_irrigacao against a cycle-level
// behavioural model of the watering schedule.
module tb_controle_irrigacao;

  localparam int IT = 8;
  localparam int DT = 4;

  logic       clk;
  logic       reset;
  logic       gatilho_in;
  logic [1:0] umidade;
  logic       nivel_l;
  logic       nivel_m;
  logic       nivel_h;
  logic       modo;
  logic       valvula_asp;
  logic       valvula_got;
  logic       alarme;
  logic       erro_sensor;
  logic [2:0] estado;
  logic [7:0] ciclos;

  controle_irrigacao #(
    .IRRIG_TICKS(IT),
    .DRAIN_TICKS(DT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .gatilho_in (gatilho_in),
    .umidade    (umidade),
    .nivel_l    (nivel_l),
    .nivel_m    (nivel_m),
    .nivel_h    (nivel_h),
    .modo       (modo),
    .valvula_asp(valvula_asp),
    .valvula_got(valvula_got),
    .alarme     (alarme),
    .erro_sensor(erro_sensor),
    .estado     (estado),
    .ciclos     (ciclos)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_err;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      if (n_err <= 40)
        $display("FAIL %s: got %0d expected %0d at %0t",
                 tag, obs, exp_v, $time);
    end
  endtask

  // model: history of sampled inputs (index 0 = newest sample)
  bit       g_h[4];
  bit [1:0] u_h[4];
  bit [2:0] n_h[4];
  bit       m_h[4];

  int m_phase;
  int m_age;
  int m_dur;
  bit m_drip;
  bit m_alarm;
  int m_cyc;

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) begin
      g_h[i] = 0; u_h[i] = 0; n_h[i] = 0; m_h[i] = 0;
    end
    m_phase = 0;
    m_age   = 0;
    m_dur   = 0;
    m_drip  = 0;
    m_alarm = 0;
  endfunction

  function automatic void start_drain();
    m_phase = 3;
    m_age   = 0;
  endfunction

  function automatic void model_step();
    bit       edge_seen;
    bit       fault;
    bit       tank_ok;
    bit [1:0] u;
    for (int i = 3; i > 0; i--) begin
      g_h[i] = g_h[i-1]; u_h[i] = u_h[i-1];
      n_h[i] = n_h[i-1]; m_h[i] = m_h[i-1];
    end
    g_h[0] = gatilho_in;
    u_h[0] = umidade;
    n_h[0] = {nivel_h, nivel_m, nivel_l};
    m_h[0] = modo;
    edge_seen = g_h[2] && !g_h[3];
    fault     = (n_h[2][2] && !n_h[2][1]) || (n_h[2][1] && !n_h[2][0]);
    tank_ok   = n_h[2][0];
    u         = u_h[2];
    case (m_phase)
      0: if (edge_seen) m_phase = 1;
      1: begin
        if (fault) m_phase = 4;
        else if (!tank_ok) begin m_alarm = 1; m_phase = 0; end
        else if (u >= 2) m_phase = 0;
        else begin
          m_alarm = 0;
          m_drip  = m_h[2];
          m_dur   = m_drip ? 2 * IT : IT;
          m_age   = 0;
          m_phase = 2;
        end
      end
      2: begin
        if (fault) m_phase = 4;
        else if (!tank_ok) begin m_alarm = 1; start_drain(); end
        else if (u == 3) start_drain();
        else if (m_age + 1 == m_dur) begin
          m_cyc = (m_cyc < 255) ? m_cyc + 1 : 255;
          start_drain();
        end else m_age++;
      end
      3: begin
        if (m_age + 1 == DT) m_phase = 0;
        else m_age++;
      end
      default: ;
    endcase
  endfunction

  task automatic compare_all();
    check("estado", estado, m_phase);
    check("valvula_asp", valvula_asp, (m_phase == 2) && !m_drip);
    check("valvula_got", valvula_got, (m_phase == 2) && m_drip);
    check("alarme", alarme, m_alarm);
    check("erro_sensor", erro_sensor, m_phase == 4);
    check("ciclos", ciclos, m_cyc);
  endtask

  task automatic hard_reset();
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    m_cyc = 0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic advance();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic set_levels(input bit [2:0] hml);
    {nivel_h, nivel_m, nivel_l} = hml;
  endtask

  task automatic randomise_inputs(input int p_trig, input bit allow_fault);
    int r;
    if ($urandom_range(0, 99) < p_trig) gatilho_in = ~gatilho_in;
    if ($urandom_range(0, 99) < 5) begin
      r = $urandom_range(0, 9);
      umidade = (r < 4) ? 2'b00 : (r < 7) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
    end
    if ($urandom_range(0, 99) < 4) begin
      r = $urandom_range(0, 19);
      if (allow_fault && r == 0) set_levels(3'b100);
      else if (allow_fault && r == 1) set_levels(3'b010);
      else if (r < 5) set_levels(3'b000);
      else if (r < 12) set_levels(3'b001);
      else if (r < 16) set_levels(3'b011);
      else set_levels(3'b111);
    end
    if ($urandom_range(0, 99) < 5) modo = ~modo;
  endtask

  initial begin
    int on_cnt;
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    gatilho_in = 0; umidade = 0; modo = 0;
    set_levels(3'b001);
    model_reset();
    m_cyc = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    compare_all();

    // directed sprinkler cycle
    on_cnt = 0;
    gatilho_in = 1'b1;
    for (int c = 0; c < 25; c++) begin
      if (c == 2) gatilho_in = 1'b0;
      advance();
      if (valvula_asp) on_cnt++;
    end
    check("asp_len", on_cnt, IT);
    check("ciclos_first", ciclos, 1);

    // randomised episodes, each starting from reset
    for (int e = 0; e < 12; e++) begin
      hard_reset();
      compare_all();
      for (int c = 0; c < 600; c++) begin
        randomise_inputs(4 + e, (e % 4) == 3);
        if ((e % 3) == 1 && m_phase == 2 && $urandom_range(0, 9) == 0) begin
          reset = 1'b1;
          #1;
          check("rst_asp", valvula_asp, 0);
          check("rst_got", valvula_got, 0);
          check("rst_estado", estado, 0);
          model_reset();
          m_cyc = 0;
          @(posedge clk);
          @(negedge clk);
          reset = 1'b0;
          compare_all();
        end else begin
          advance();
        end
      end
    end

    // saturation of the completion counter
    hard_reset();
    umidade = 2'b00;
    modo = 1'b0;
    set_levels(3'b001);
    for (int w = 0; w < 262; w++) begin
      for (int c = 0; c < 18; c++) begin
        gatilho_in = (c < 2);
        advance();
      end
    end
    check("ciclos_sat", ciclos, 255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/controle_irrigacao.md
# controle_irrigacao

Irrigation sequencer for the irrigation system. It takes the trigger pulse train produced by the `gatilho` stage together with the soil-moisture and tank-level sensors. It decides whether to water, drives the sprinkler or drip valve for a timed interval and then enforces a cooldown. Tank-low and sensor-inconsistency conditions are reported to the display/alarm logic downstream.

## Interface
Parameters:
- `IRRIG_TICKS`, default 8: watering duration in `clk` cycles for sprinkler mode; drip mode uses 2×`IRRIG_TICKS`. Must be ≥1.
- `DRAIN_TICKS`, default 4: cooldown length in `clk` cycles after watering. Must be ≥1.

Ports:
- `clk` in 1: system clock. All state changes on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `gatilho_in` in 1: trigger from `gatilho`. Asynchronous to `clk`; only rising edges matter.
- `umidade` in 2: soil moisture. 00 dry, 01 low, 10 ok, 11 saturated.
- `nivel_l`, `nivel_m`, `nivel_h` in 1 each: tank level probes. 1 means water is at or above that probe.
- `modo` in 1: 0 selects sprinkler, 1 selects drip.
- `valvula_asp` out 1: sprinkler valve.
- `valvula_got` out 1: drip valve.
- `alarme` out 1: tank-low alarm.
- `erro_sensor` out 1: sticky sensor-fault flag.
- `estado` out 3: current FSM state encoding.
- `ciclos` out 8: count of completed full-duration waterings, saturating.

## Operation
- **Input synchronisation:** `gatilho_in`, `umidade`, all `nivel_*` and `modo` pass through 2-FF synchronizers. All decisions use synchronized values only.
- **Trigger edge:** detected as the synchronized trigger = 1 while its previous value = 0.
- **Level fault:** invalid when (`nivel_h` & ~`nivel_m`) or (`nivel_m` & ~`nivel_l`).
- **FSM states:** IDLE=0, CHECK=1, REGA=2, PAUSA=3, ERRO=4. Encodings 5–7 are unreachable; if ever entered, return to IDLE.
- **IDLE:** valves off. On a trigger edge go to CHECK. Otherwise stay.
- **CHECK** (exactly 1 cycle). First matching rule wins:
  - Level fault: go to ERRO.
  - `nivel_l`=0: set `alarme`, go to IDLE.
  - `umidade` ≥ 10: go to IDLE (no watering needed).
  - Otherwise: clear `alarme`, latch `modo`, load counter with D (`IRRIG_TICKS`, or 2×`IRRIG_TICKS` for drip), go to REGA.
- **REGA:** the valve for the latched mode is 1 and the other valve is 0. Each cycle is evaluated in this priority order:
  1. Level fault: go to ERRO.
  2. `nivel_l`=0: set `alarme`, go to PAUSA.
  3. `umidade`=11: go to PAUSA (early stop).
  4. Counter =1: increment `ciclos` (saturate at 255), go to PAUSA.
  5. Otherwise: decrement the counter.
- **PAUSA:** valves off. Counts `DRAIN_TICKS` cycles, then goes to IDLE. Trigger edges are ignored and not queued.
- **ERRO:** valves off, `erro_sensor`=1. Stays in ERRO until `reset`.
- **Trigger edges outside IDLE** are dropped.
- **Mode change during REGA:** `modo` changes do not affect the running cycle.
- **Counter width:** wide enough to hold 2×`IRRIG_TICKS`.

## Timing
- **Reset values:** state IDLE; `valvula_asp`=0, `valvula_got`=0, `alarme`=0, `erro_sensor`=0, `estado`=0, `ciclos`=0; synchronizers cleared.
- **Reset mid-watering:** valves drop immediately (asynchronous). No `ciclos` increment.
- **Outputs:** registered, Moore. Valves and `estado` follow the state register with no combinational path from inputs.
- **Trigger latency:** input rising edge sampled at clk edge k → CHECK at edge k+2 → REGA at edge k+3, so the valve is 1 from edge k+3.
- **Sensor latency:** sensor changes take effect 2 cycles after sampling, plus the 1-cycle decision.
- **Uninterrupted watering:** valve is high for exactly D cycles, then low for exactly `DRAIN_TICKS` cycles in PAUSA, then IDLE.
- **Abort in REGA:** the valve falls at the same edge the state leaves REGA.
- **Saturation:** at `ciclos`=255, completion leaves it at 255.

## Test plan
- **Sprinkler, full cycle.** Parameters 8/4; `umidade`=00, levels=001, `modo`=0; one trigger pulse.
  - `valvula_asp` high exactly 8 cycles, starting 3 cycles after the sampled edge.
  - `valvula_got`=0 throughout; `ciclos`=1.
  - `estado` sequence 0→1→2→3→0, with PAUSA lasting 4 cycles.
- **Drip, with retrigger.** `modo`=1.
  - `valvula_got` high 16 cycles.
  - A second trigger during REGA or PAUSA produces no extra cycle.
  - Toggling `modo` mid-REGA has no effect.
- **Skip and tank-low cases.**
  - `umidade`=10, then trigger: CHECK→IDLE, valves never open, `ciclos` unchanged.
  - Levels=000, then trigger: `alarme`=1, no valve.
  - A later valid trigger with levels=001 clears `alarme`.
- **Early stops.** Start watering, then drive `umidade`=11 at REGA cycle 3: valve falls, PAUSA runs, `ciclos` unchanged. Repeat with `nivel_l` falling to 0: same, and `alarme`=1.
- **Sensor fault.** Levels=100 during REGA: ERRO, valves 0, `erro_sensor`=1. Further triggers ignored until `reset`; after `reset` all outputs return to reset values.
- **Async reset during REGA.** Assert `reset` mid-REGA: valves 0 before the next clk edge, `estado`=0. Also preload 255 completions and run one more cycle: `ciclos` stays 255.
